// File: rtl/cube_move_issuer.sv
// Buffers decoder move codes and issues each to the cube colour controller as a stable command
// plus a one-cycle ischanged strobe with a forced gap. Optional undo LIFO: define CUBE_UNDO_EN.
module cube_move_issuer #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int GAP      = 4,
    parameter int CODE_MAX = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      move_in,
    input  logic            move_valid,
    output logic            move_ready,
    input  logic            armed,
    input  logic            flush,
    input  logic            undo_req,
    output logic [4:0]      command,
    output logic            ischanged,
    output logic            busy,
    output logic [ADDR_W:0] count,
    output logic            err,
    output logic [1:0]      state_dbg
);
    // Push handshake: a code transfers on a rising clk edge where move_valid && move_ready;
    // move_ready depends only on count and flush, never on a same-cycle pop.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(2);
    localparam logic [4:0]        CODE_LIM = 5'(CODE_MAX);

    state_t            state, state_n;
    logic [4:0]        fifo_mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic              push, push_ok, pop, issue;
    logic [4:0]        issue_code;
    logic [4:0]        head;

    assign head       = fifo_mem[rd_ptr];
    assign move_ready = (count < FULL_CNT) && !flush;
    assign push       = move_valid && move_ready;
    assign push_ok    = push && (move_in <= CODE_LIM);
    assign busy       = (state != IDLE) || (count != '0);
    assign state_dbg  = state;

`ifdef CUBE_UNDO_EN
    logic [4:0]        lifo_mem [DEPTH];
    logic [ADDR_W-1:0] lifo_top, lifo_prev;
    logic [ADDR_W:0]   lifo_cnt;
    logic              undo_pend, undo_take, undo_drop;

    assign lifo_prev = lifo_top - PTR_ONE;
`else
    logic unused_undo;
    assign unused_undo = undo_req;
`endif

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_code = command;
`ifdef CUBE_UNDO_EN
        undo_take  = 1'b0;
        undo_drop  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (armed) begin
`ifdef CUBE_UNDO_EN
                    // A pending undo outranks queued moves; with nothing to undo it is dropped.
                    if (undo_pend && (lifo_cnt != '0)) begin
                        undo_take  = 1'b1;
                        issue      = 1'b1;
                        issue_code = lifo_mem[lifo_prev] ^ 5'd1;
                    end else begin
                        undo_drop = undo_pend;
                    end
`endif
                    if (!issue && (count != '0)) begin
                        pop        = 1'b1;
                        issue      = 1'b1;
                        issue_code = head;
                    end
                end
            end
            // HOLD ends as the counter steps down to 1, so strobes land GAP+1 cycles apart.
            ISSUE:   state_n = (GAP == 1) ? IDLE : HOLD;
            HOLD:    if (gap_cnt <= GAP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (issue) state_n = ISSUE;
        if (flush) begin
            state_n = IDLE;
            pop     = 1'b0;
            issue   = 1'b0;
`ifdef CUBE_UNDO_EN
            undo_take = 1'b0;
            undo_drop = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= move_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            command   <= '0;
            ischanged <= 1'b0;
            gap_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            if (push && !push_ok) err <= 1'b1;
            if (flush) begin
                ischanged <= 1'b0;
                gap_cnt   <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
            end else begin
                ischanged <= issue;
                if (issue) command <= issue_code;
                if (state == ISSUE) gap_cnt <= GAP_LOAD;
                else if (state == HOLD) gap_cnt <= gap_cnt - GAP_ONE;
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                if (push_ok && !pop) count <= count + CNT_ONE;
                else if (pop && !push_ok) count <= count - CNT_ONE;
            end
        end
    end

`ifdef CUBE_UNDO_EN
    // Circular LIFO: once full, a new entry silently replaces the oldest one.
    always_ff @(posedge clk) begin
        if (pop) lifo_mem[lifo_top] <= head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lifo_top  <= '0;
            lifo_cnt  <= '0;
            undo_pend <= 1'b0;
        end else if (flush) begin
            lifo_top  <= '0;
            lifo_cnt  <= '0;
            undo_pend <= 1'b0;
        end else begin
            if (pop) begin
                lifo_top <= lifo_top + PTR_ONE;
                if (lifo_cnt != FULL_CNT) lifo_cnt <= lifo_cnt + CNT_ONE;
            end else if (undo_take) begin
                lifo_top <= lifo_prev;
                lifo_cnt <= lifo_cnt - CNT_ONE;
            end
            undo_pend <= (undo_pend && !undo_take && !undo_drop) || undo_req;
        end
    end
`endif

endmodule

// File: tb/tb_cube_move_issuer.sv
// Bench for cube_move_issuer: queue-based timing model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_cube_move_issuer;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int GAP      = 4;
    localparam int CODE_MAX = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0]        move_in = '0;
    logic              move_valid = 1'b0;
    logic              move_ready;
    logic              armed = 1'b0;
    logic              flush = 1'b0;
    logic              undo_req = 1'b0;
    logic [4:0]        command;
    logic              ischanged;
    logic              busy;
    logic [ADDR_W:0]   count;
    logic              err;
    logic [1:0]        state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: pending codes, last strobe cycle, undo history.
    logic [4:0] exp_q[$];
    logic [4:0] lifo_q[$];
    logic [4:0] m_cmd;
    logic       m_stb, m_err, m_pend, m_issued;
    int         m_last, m_n;

    int         s_cyc[$];
    logic [4:0] s_cmd[$];

    cube_move_issuer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP(GAP), .CODE_MAX(CODE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .move_in(move_in), .move_valid(move_valid),
        .move_ready(move_ready), .armed(armed), .flush(flush), .undo_req(undo_req),
        .command(command), .ischanged(ischanged), .busy(busy), .count(count),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // An issue may start in any cycle at least GAP cycles after the previous strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            lifo_q.delete();
            m_cmd  = '0;
            m_stb  = 1'b0;
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_last = -1000;
        end else begin
            m_n   = exp_q.size();
            m_stb = 1'b0;
            if (flush) begin
                exp_q.delete();
                lifo_q.delete();
                m_pend = 1'b0;
                m_last = -1000;
            end else begin
                m_issued = 1'b0;
                if (armed && (cyc >= m_last + GAP)) begin
`ifdef CUBE_UNDO_EN
                    if (m_pend) begin
                        m_pend = 1'b0;
                        if (lifo_q.size() > 0) begin
                            m_cmd    = lifo_q.pop_back() ^ 5'd1;
                            m_issued = 1'b1;
                        end
                    end
`endif
                    if (!m_issued && (m_n > 0)) begin
                        m_cmd    = exp_q.pop_front();
                        m_issued = 1'b1;
                        lifo_q.push_back(m_cmd);
                        if (lifo_q.size() > DEPTH) void'(lifo_q.pop_front());
                    end
                    if (m_issued) begin
                        m_stb  = 1'b1;
                        m_last = cyc + 1;
                    end
                end
                if (move_valid && (m_n < DEPTH)) begin
                    if (move_in <= CODE_MAX) exp_q.push_back(move_in);
                    else m_err = 1'b1;
                end
`ifdef CUBE_UNDO_EN
                if (undo_req) m_pend = 1'b1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("command", command, m_cmd);
            chk("ischanged", ischanged, m_stb);
            chk("count", count, exp_q.size());
            chk("err", err, m_err);
            chk("busy", busy, (exp_q.size() > 0) || (cyc < m_last + GAP));
            chk("move_ready", move_ready, (exp_q.size() < DEPTH) && !flush);
            chk("state", state_dbg, (cyc == m_last) ? 1 : ((cyc < m_last + GAP) ? 2 : 0));
            if (ischanged) begin
                s_cyc.push_back(cyc);
                s_cmd.push_back(command);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input logic [4:0] code);
        move_valid = 1'b1;
        move_in    = code;
        step();
        move_valid = 1'b0;
    endtask

    task automatic settle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (8) step();
        s_cyc.delete();
        s_cmd.delete();
    endtask

    function automatic int s_cyc_at(input int i);
        return (i < s_cyc.size()) ? s_cyc[i] : -1;
    endfunction

    function automatic int s_cmd_at(input int i);
        return (i < s_cmd.size()) ? int'(s_cmd[i]) : -1;
    endfunction

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got time limit, expected bench completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int p, k;
        logic [4:0] codes [9];

        repeat (2) @(posedge clk);
        #1;
        chk("rst_command", command, 0);
        chk("rst_ischanged", ischanged, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        step();

        // Single move
        settle();
        armed = 1'b1;
        p = cyc;
        push_code(5'd0);
        repeat (6) step();
        chk("single_busy_low", busy, 0);
        chk("single_strobes", s_cyc.size(), 1);
        chk("single_cyc", s_cyc_at(0), p + 2);
        chk("single_cmd", s_cmd_at(0), 0);

        // Burst of three
        settle();
        p = cyc;
        push_code(5'd2);
        push_code(5'd4);
        push_code(5'd17);
        repeat (12) step();
        chk("burst_strobes", s_cyc.size(), 3);
        chk("burst_cyc0", s_cyc_at(0), p + 2);
        chk("burst_cyc1", s_cyc_at(1), p + 7);
        chk("burst_cyc2", s_cyc_at(2), p + 12);
        chk("burst_cmd0", s_cmd_at(0), 2);
        chk("burst_cmd1", s_cmd_at(1), 4);
        chk("burst_cmd2", s_cmd_at(2), 17);

        // Full FIFO while disarmed, then drain
        settle();
        armed = 1'b0;
        for (int i = 0; i < 9; i++) codes[i] = 5'($urandom_range(0, CODE_MAX));
        for (int i = 0; i < 8; i++) push_code(codes[i]);
        move_valid = 1'b1;
        move_in    = codes[8];
        chk("full_ready_low", move_ready, 0);
        chk("full_count", count, 8);
        armed = 1'b1;
        k = 0;
        while (!move_ready && (k < 20)) begin
            step();
            k++;
        end
        chk("full_accept_in_time", (k < 20), 1);
        step();
        move_valid = 1'b0;
        repeat (60) step();
        chk("full_strobes", s_cyc.size(), 9);
        for (int i = 0; i < 9; i++) chk("full_order", s_cmd_at(i), codes[i]);
        for (int i = 0; i < 8; i++) chk("full_spacing", s_cyc_at(i + 1) - s_cyc_at(i), GAP + 1);

        // Flush during HOLD with two queued moves
        settle();
        p = cyc;
        push_code(5'd3);
        push_code(5'd5);
        push_code(5'd8);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_state_idle", state_dbg, 0);
        chk("flush_no_strobe", ischanged, 0);
        push_code(5'd11);
        repeat (8) step();
        chk("flush_strobes", s_cyc.size(), 2);
        chk("flush_cyc0", s_cyc_at(0), p + 2);
        chk("flush_cmd0", s_cmd_at(0), 3);
        chk("flush_cyc1", s_cyc_at(1), p + 7);
        chk("flush_cmd1", s_cmd_at(1), 11);

        // Illegal code
        settle();
        chk("illegal_err_before", err, 0);
        p = cyc;
        push_code(5'd20);
        push_code(5'd1);
        repeat (8) step();
        chk("illegal_err", err, 1);
        chk("illegal_strobes", s_cyc.size(), 1);
        chk("illegal_cyc", s_cyc_at(0), p + 3);
        chk("illegal_cmd", s_cmd_at(0), 1);

        // Reset in the ISSUE cycle
        settle();
        push_code(5'd9);
        step();
        chk("midrst_issue", ischanged, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_command", command, 0);
        chk("midrst_ischanged", ischanged, 0);
        chk("midrst_count", count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("midrst_no_strobe", s_cyc.size(), 0);

`ifdef CUBE_UNDO_EN
        // Undo of l, then an undo with empty history
        settle();
        armed = 1'b1;
        p = cyc;
        push_code(5'd6);
        repeat (6) step();
        undo_req = 1'b1;
        step();
        undo_req = 1'b0;
        repeat (6) step();
        undo_req = 1'b1;
        step();
        undo_req = 1'b0;
        repeat (10) step();
        chk("undo_strobes", s_cyc.size(), 2);
        chk("undo_cmd", s_cmd_at(1), 7);
        chk("undo_cyc", s_cyc_at(1), p + 9);
`endif

        // Randomized traffic
        settle();
        armed = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) armed = ~armed;
            flush      = ($urandom_range(0, 59) == 0);
            undo_req   = ($urandom_range(0, 24) == 0);
            move_valid = ($urandom_range(0, 9) < 6);
            move_in    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(18, 31))
                                                      : 5'($urandom_range(0, CODE_MAX));
            step();
        end
        move_valid = 1'b0;
        flush      = 1'b0;
        undo_req   = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cube_move_issuer.md
Name: cube_move_issuer

Overview:
- Sits directly upstream of the cube colour controller.
- Buffers move codes from the keypad/keyboard decoder in a small FIFO.
- Issues each move to the controller as a stable 5-bit command plus a single-cycle ischanged strobe, with a guaranteed gap between strobes.
- A held or repeated strobe can never rotate the cube more than once per move.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3: log2(DEPTH).
- GAP, 4: idle cycles forced after each strobe; at least 1.
- CODE_MAX, 17: highest legal move code (r=0 … d'=17; the inverse of a code is the code XOR 1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- move_in, input, 5: move code offered by the upstream decoder.
- move_valid, input, 1: move_in is valid this cycle.
- move_ready, output, 1: a push is accepted when move_valid && move_ready.
- armed, input, 1: high while the cube is in play state (choosing==0 && entercnt>=2); computed externally.
- flush, input, 1: synchronous clear of pending work.
- undo_req, input, 1: single-cycle undo request; used only with UNDO_EN.
- command, output, 5: move code to the controller; registered.
- ischanged, output, 1: one-cycle strobe; registered.
- busy, output, 1: high when state is not IDLE or the FIFO is non-empty.
- count, output, ADDR_W+1: current FIFO occupancy.
- err, output, 1: sticky; set when an illegal code is pushed.

Behaviour:
- Reset, asynchronous: command=0, ischanged=0, count=0, err=0, state=IDLE, FIFO pointers=0, gap counter=0, undo stack empty.
- move_ready = (count < DEPTH) && !flush. This is combinational and does not depend on a same-cycle pop, so a full FIFO refuses a push even in a pop cycle.
- Push with move_in > CODE_MAX:
  - the code is not stored;
  - err is set and stays set until rst;
  - the handshake still completes, i.e. the word is consumed.
- Simultaneous legal push and pop: count is unchanged, the write lands at the tail and the read is taken from the old head.
- Pointers wrap modulo DEPTH.
- State machine, states IDLE, ISSUE, HOLD:
  - IDLE: if armed && count>0, take the head entry. On the next edge command<=head, ischanged<=1, pop, and go to ISSUE.
  - ISSUE: lasts exactly one cycle with ischanged=1. On the next edge ischanged<=0, the gap counter loads GAP, and the state goes to HOLD.
  - HOLD: the gap counter decrements each cycle and command is held stable. When the counter reaches 1, the state returns to IDLE on the next edge.
- Minimum strobe spacing is GAP+1 cycles. With GAP=4, back-to-back strobes fall at cycles t and t+5.
- Latency from an accepted push into an empty, idle, armed block to the ischanged rising edge is 2 cycles. The push registers first, then IDLE issues.
- armed going low:
  - no new issue is started from IDLE;
  - an ISSUE/HOLD already in progress completes normally;
  - the FIFO contents are kept.
- flush has priority over everything in its cycle:
  - FIFO is cleared (count=0);
  - state goes to IDLE;
  - ischanged is forced to 0 on the next edge;
  - command holds its last value;
  - err is unaffected.
- command always changes on the same edge that raises ischanged, never while ischanged is high.
- Reset mid-HOLD or mid-ISSUE: outputs return to reset values immediately; no strobe completes.

Optional Feature:
- Macro: CUBE_UNDO_EN.
- Defined:
  - A DEPTH-entry LIFO records every move issued from the FIFO.
  - undo_req sets a pending flag. In IDLE a pending undo has priority over the FIFO. If the LIFO is non-empty, the block issues (top XOR 1) using the normal ISSUE/HOLD timing, pops the LIFO, and does not record the undo move.
  - A pending undo with an empty LIFO is discarded.
  - When the LIFO is full, pushing a new move overwrites the oldest entry.
  - flush clears both the LIFO and the pending flag.
  - Undo is gated by armed exactly like FIFO moves.
- Not defined: undo_req is ignored and no LIFO storage is synthesised.

Test Plan:
- Single move: armed=1, push 5'd0 (r) at cycle 0 -> ischanged=1 with command=0 at cycle 2 only; busy low at cycle 2+GAP+1.
- Burst of 3 moves: push codes 2, 4, 17 on consecutive cycles, GAP=4 -> strobes at cycles 2, 7, 12 carrying 2, 4, 17; count peaks at 3.
- Full FIFO: disarmed, push 9 legal codes -> the first 8 are accepted and the 9th waits with move_ready=0. Then arm -> the 8 strobes come out in order and the 9th is accepted once count<8.
- Illegal code: push 5'd20 then 5'd1 -> err=1, only command=1 is strobed, count never exceeds 1.
- Flush during HOLD with 2 queued moves -> no further strobes, count=0, state IDLE the next cycle. A new push is strobed 2 cycles later.
- UNDO (CUBE_UNDO_EN): issue 6 (l), then pulse undo_req -> next strobe has command=7 (l'). A second undo_req produces no strobe.
